// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : Encodings shared by the multicycle RV32I control unit.
// Revision : 1.0
// ============================================================================
package riscv_ctrl_pkg;

    localparam logic [3:0] c_st_fetch    = 4'd0;
    localparam logic [3:0] c_st_decode   = 4'd1;
    localparam logic [3:0] c_st_memadr   = 4'd2;
    localparam logic [3:0] c_st_memread  = 4'd3;
    localparam logic [3:0] c_st_memwb    = 4'd4;
    localparam logic [3:0] c_st_memwrite = 4'd5;
    localparam logic [3:0] c_st_executer = 4'd6;
    localparam logic [3:0] c_st_executei = 4'd7;
    localparam logic [3:0] c_st_aluwb    = 4'd8;
    localparam logic [3:0] c_st_beq      = 4'd9;
    localparam logic [3:0] c_st_jal      = 4'd10;
    localparam logic [3:0] c_st_illegal  = 4'd11;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_xor = 3'b100;
    localparam logic [2:0] c_alu_slt = 3'b101;
    localparam logic [2:0] c_alu_sll = 3'b110;
    localparam logic [2:0] c_alu_srl = 3'b111;

    localparam logic       c_adr_pc       = 1'b0;
    localparam logic       c_adr_aluout   = 1'b1;
    localparam logic [1:0] c_res_aluout   = 2'b00;
    localparam logic [1:0] c_res_data     = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;
    localparam logic [1:0] c_srca_pc      = 2'b00;
    localparam logic [1:0] c_srca_oldpc   = 2'b01;
    localparam logic [1:0] c_srca_rs1     = 2'b10;
    localparam logic [1:0] c_srcb_rs2     = 2'b00;
    localparam logic [1:0] c_srcb_imm     = 2'b01;
    localparam logic [1:0] c_srcb_four    = 2'b10;
    localparam logic [1:0] c_imm_i        = 2'b00;
    localparam logic [1:0] c_imm_s        = 2'b01;
    localparam logic [1:0] c_imm_b        = 2'b10;
    localparam logic [1:0] c_imm_j        = 2'b11;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            c_op_store:  return c_imm_s;
            c_op_branch: return c_imm_b;
            c_op_jal:    return c_imm_j;
            default:     return c_imm_i;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps alu_op plus instruction function bits to an ALU opcode.
// Revision : 1.0
// ============================================================================
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = c_alu_add;
        case (alu_op)
            c_aluop_add: alu_control = c_alu_add;
            c_aluop_sub: alu_control = c_alu_sub;
            c_aluop_funct: begin
                case (funct3)
                    // funct7b5 means sub only for register operands; addi ignores it
                    3'b000:  alu_control = (op5 & funct7b5) ? c_alu_sub : c_alu_add;
                    3'b111:  alu_control = c_alu_and;
                    3'b110:  alu_control = c_alu_or;
                    3'b100:  alu_control = c_alu_xor;
                    3'b010:  alu_control = c_alu_slt;
                    3'b001:  alu_control = c_alu_sll;
                    3'b101:  alu_control = c_alu_srl;
                    default: alu_control = c_alu_add;
                endcase
            end
            default: alu_control = c_alu_add;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Moore FSM sequencing the shared multicycle RV32I datapath.
// Revision : 1.0
// ============================================================================
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W  = 4,
    parameter int ALUCTL_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                funct7b5,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                adr_src,
    output logic                mem_write,
    output logic                ir_write,
    output logic [1:0]          result_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          imm_src,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                reg_write,
    output logic                instr_retire,
    output logic                illegal_instr,
    output logic [STATE_W-1:0]  state_o
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_pc_update, w_branch, w_mem_write, w_ir_write;
    logic       w_reg_write, w_retire, w_illegal;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_ctl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_fetch;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = c_st_illegal;
        case (r_state)
            c_st_fetch:    w_next_state = mem_ready ? c_st_decode : c_st_fetch;
            c_st_decode: begin
                case (op)
                    c_op_load, c_op_store: w_next_state = c_st_memadr;
                    c_op_rtype:            w_next_state = c_st_executer;
                    c_op_itype:            w_next_state = c_st_executei;
                    c_op_branch:           w_next_state = c_st_beq;
                    c_op_jal:              w_next_state = c_st_jal;
                    default:               w_next_state = c_st_illegal;
                endcase
            end
            c_st_memadr:   w_next_state = op[5] ? c_st_memwrite : c_st_memread;
            c_st_memread:  w_next_state = mem_ready ? c_st_memwb : c_st_memread;
            c_st_memwb:    w_next_state = c_st_fetch;
            c_st_memwrite: w_next_state = mem_ready ? c_st_fetch : c_st_memwrite;
            c_st_executer: w_next_state = c_st_aluwb;
            c_st_executei: w_next_state = c_st_aluwb;
            c_st_aluwb:    w_next_state = c_st_fetch;
            c_st_beq:      w_next_state = c_st_fetch;
            c_st_jal:      w_next_state = c_st_aluwb;
            default:       w_next_state = c_st_illegal;
        endcase
    end

    always_comb begin
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_retire    = 1'b0;
        w_illegal   = 1'b0;
        w_alu_op    = c_aluop_add;
        adr_src     = c_adr_pc;
        result_src  = c_res_aluout;
        alu_src_a   = c_srca_pc;
        alu_src_b   = c_srcb_rs2;
        case (r_state)
            c_st_fetch: begin
                alu_src_b   = c_srcb_four;
                result_src  = c_res_aluresult;
                w_ir_write  = mem_ready;
                w_pc_update = mem_ready;
            end
            c_st_decode: begin
                alu_src_a = c_srca_oldpc;
                alu_src_b = c_srcb_imm;
            end
            c_st_memadr: begin
                alu_src_a = c_srca_rs1;
                alu_src_b = c_srcb_imm;
            end
            c_st_memread: adr_src = c_adr_aluout;
            c_st_memwb: begin
                result_src  = c_res_data;
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            c_st_memwrite: begin
                adr_src     = c_adr_aluout;
                w_mem_write = 1'b1;
                w_retire    = mem_ready;
            end
            c_st_executer: begin
                alu_src_a = c_srca_rs1;
                w_alu_op  = c_aluop_funct;
            end
            c_st_executei: begin
                alu_src_a = c_srca_rs1;
                alu_src_b = c_srcb_imm;
                w_alu_op  = c_aluop_funct;
            end
            c_st_aluwb: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            c_st_beq: begin
                alu_src_a = c_srca_rs1;
                w_alu_op  = c_aluop_sub;
                w_branch  = 1'b1;
                w_retire  = 1'b1;
            end
            c_st_jal: begin
                alu_src_a   = c_srca_oldpc;
                alu_src_b   = c_srcb_four;
                w_pc_update = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (op[5]),
        .alu_control (w_alu_ctl)
    );

    // Enables are held low for the whole reset window, even with mem_ready high.
    assign pc_write      = rst_n & (w_pc_update | (w_branch & zero));
    assign mem_write     = rst_n & w_mem_write;
    assign ir_write      = rst_n & w_ir_write;
    assign reg_write     = rst_n & w_reg_write;
    assign instr_retire  = rst_n & w_retire;
    assign illegal_instr = w_illegal;
    assign imm_src       = imm_src_for(op);
    assign alu_control   = ALUCTL_W'(w_alu_ctl);
    assign state_o       = STATE_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized scoreboard bench for the multicycle control FSM.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_retire, illegal_instr;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    multicycle_controller #(.STATE_W(4), .ALUCTL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .reg_write(reg_write), .instr_retire(instr_retire),
        .illegal_instr(illegal_instr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] st; logic bad; } cyc_t;
    typedef struct {
        int ncyc; int nregw; int nmemw; int npcw;
        logic [2:0] aluc; int aluc_idx; logic [1:0] rsrc; logic [1:0] imm;
    } rec_t;

    cyc_t cyc_q[$];
    rec_t rec_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU opcode straight from the instruction-set table.
    function automatic logic [2:0] ref_aluc(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (o == c_op_branch) return 3'b001;
        if (o != c_op_rtype && o != c_op_itype) return 3'b000;
        case (f3)
            3'b000:  return (o == c_op_rtype && f7) ? 3'b001 : 3'b000;
            3'b111:  return 3'b010;
            3'b110:  return 3'b011;
            3'b100:  return 3'b100;
            3'b010:  return 3'b101;
            3'b001:  return 3'b110;
            default: return 3'b111;
        endcase
    endfunction

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            zero = 1'b1;
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int sf, input int sm, input int abort_at);
        logic [3:0] sched[$];
        rec_t r;
        int   m = 0;
        for (int i = 0; i <= sf; i++) sched.push_back(c_st_fetch);
        sched.push_back(c_st_decode);
        case (o)
            c_op_load: begin
                sched.push_back(c_st_memadr);
                for (int i = 0; i <= sm; i++) sched.push_back(c_st_memread);
                sched.push_back(c_st_memwb);
            end
            c_op_store: begin
                sched.push_back(c_st_memadr);
                for (int i = 0; i <= sm; i++) sched.push_back(c_st_memwrite);
            end
            c_op_rtype:  begin sched.push_back(c_st_executer); sched.push_back(c_st_aluwb); end
            c_op_itype:  begin sched.push_back(c_st_executei); sched.push_back(c_st_aluwb); end
            c_op_branch: sched.push_back(c_st_beq);
            c_op_jal:    begin sched.push_back(c_st_jal); sched.push_back(c_st_aluwb); end
            default:     for (int i = 0; i < 20; i++) sched.push_back(c_st_illegal);
        endcase
        r.ncyc     = sched.size();
        r.nregw    = (o == c_op_load || o == c_op_rtype || o == c_op_itype || o == c_op_jal) ? 1 : 0;
        r.nmemw    = (o == c_op_store) ? sm + 1 : 0;
        r.npcw     = 1 + ((o == c_op_jal) ? 1 : 0) + ((o == c_op_branch && z) ? 1 : 0);
        r.aluc     = ref_aluc(o, f3, f7);
        r.aluc_idx = sf + 2;
        r.rsrc     = (o == c_op_load) ? 2'b01 : 2'b00;
        r.imm      = (o == c_op_store) ? 2'b01 : (o == c_op_branch) ? 2'b10 :
                     (o == c_op_jal) ? 2'b11 : 2'b00;
        if (abort_at < 0 && sched[sched.size()-1] != c_st_illegal) rec_q.push_back(r);
        for (int k = 0; k < sched.size(); k++) begin
            if (k == abort_at) break;
            @(negedge clk);
            rst_n = 1'b1; op = o; funct3 = f3; funct7b5 = f7;
            zero = (sched[k] == c_st_beq) ? z : 1'($urandom_range(0, 1));
            if (sched[k] == c_st_fetch) mem_ready = (k == sf);
            else if (sched[k] == c_st_memread || sched[k] == c_st_memwrite) begin
                mem_ready = (m == sm);
                m++;
            end else mem_ready = 1'($urandom_range(0, 1));
            cyc_q.push_back('{st: sched[k], bad: (sched[k] == c_st_illegal)});
        end
    endtask

    // Monitor / scoreboard
    initial begin
        int         cnt = 0, nregw = 0, nmemw = 0, npcw = 0, nirw = 0;
        logic [2:0] aluc_hist[64];
        cyc_t       c;
        rec_t       r;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                chk("rst_state", 32'(state_o), 32'(c_st_fetch));
                chk("rst_enables", 32'({pc_write, ir_write, mem_write, reg_write, instr_retire}), 0);
                chk("rst_illegal", 32'(illegal_instr), 0);
                cnt = 0; nregw = 0; nmemw = 0; npcw = 0; nirw = 0;
            end else if (cyc_q.size() == 0) begin
                chk("cycle_expected", 32'(cyc_q.size() != 0), 1);
            end else begin
                c = cyc_q.pop_front();
                chk("state", 32'(state_o), 32'(c.st));
                chk("illegal_flag", 32'(illegal_instr), 32'(c.bad));
                if (c.bad)
                    chk("illegal_enables", 32'({pc_write, ir_write, mem_write, reg_write, instr_retire}), 0);
                if (c.st == c_st_fetch)
                    chk("fetch_muxes", 32'({adr_src, alu_src_a, alu_src_b, result_src}), 32'(7'b0_00_10_10));
                if (cnt < 64) aluc_hist[cnt] = alu_control;
                cnt++;
                nregw += 32'(reg_write); nmemw += 32'(mem_write);
                npcw += 32'(pc_write); nirw += 32'(ir_write);
                if (instr_retire) begin
                    if (rec_q.size() == 0) chk("retire_expected", 32'(rec_q.size() != 0), 1);
                    else begin
                        r = rec_q.pop_front();
                        chk("latency", cnt, r.ncyc);
                        chk("reg_write_count", nregw, r.nregw);
                        chk("mem_write_count", nmemw, r.nmemw);
                        chk("pc_write_count", npcw, r.npcw);
                        chk("ir_write_count", nirw, 1);
                        chk("alu_control", 32'(aluc_hist[r.aluc_idx]), 32'(r.aluc));
                        chk("result_src_final", 32'(result_src), 32'(r.rsrc));
                        chk("imm_src", 32'(imm_src), 32'(r.imm));
                    end
                    cnt = 0; nregw = 0; nmemw = 0; npcw = 0; nirw = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [6:0] ops[6];
        logic [2:0] f3s[7];
        ops = '{c_op_load, c_op_store, c_op_rtype, c_op_itype, c_op_branch, c_op_jal};
        f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        do_reset(3);
        run_instr(c_op_rtype, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(c_op_load, 3'b010, 1'b0, 1'b0, 0, 2, -1);
        run_instr(c_op_store, 3'b010, 1'b0, 1'b0, 0, 1, -1);
        run_instr(c_op_branch, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        run_instr(c_op_branch, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(c_op_jal, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        run_instr(c_op_rtype, 3'b000, 1'b1, 1'b0, 1, 0, -1);
        for (int n = 0; n < 80; n++) begin
            run_instr(ops[$urandom_range(0, 5)], f3s[$urandom_range(0, 6)],
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end
        run_instr(c_op_load, 3'b010, 1'b0, 1'b0, 0, 3, 4);
        do_reset(2);
        run_instr(c_op_store, 3'b010, 1'b0, 1'b0, 1, 3, 5);
        do_reset(1);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        do_reset(2);
        run_instr(c_op_itype, 3'b100, 1'b1, 1'b0, 0, 0, -1);
        run_instr(c_op_load, 3'b010, 1'b0, 1'b0, 2, 1, -1);
        do_reset(2);
        chk("leftover_records", rec_q.size(), 0);
        chk("leftover_cycles", cyc_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing control unit for the multicycle RV32I datapath. It shares one memory port, one ALU and one register-file write port across the phases of each instruction.
- Decodes the registered instruction fields (op, funct3, funct7[5]).
- Drives every mux select and write enable, cycle by cycle, through a Moore FSM.
- Stalls on a memory ready handshake.
- Supports the same instruction subset as the single-cycle main decoder: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- STATE_W, 4, width of the exported state code.
- ALUCTL_W, 3, width of alu_control.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction[6:0] from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access in the current cycle
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0=PC, 1=ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction-register and OldPC enable
- result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
- alu_src_a  out  2  00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  00=rs2, 01=imm, 10=constant 4
- imm_src  out  2  00=I, 01=S, 10=B, 11=J
- alu_control  out  ALUCTL_W  ALU operation code
- reg_write  out  1  register-file write enable
- instr_retire  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_instr  out  1  sticky unsupported-opcode flag
- state_o  out  STATE_W  current state code, for debug and the bench

Behaviour:
- Reset:
  - While rst_n=0, state goes to FETCH asynchronously.
  - illegal_instr=0.
  - pc_write, mem_write, ir_write, reg_write and instr_retire are forced to 0, regardless of mem_ready.
- Outputs are combinational from state, except:
  - pc_write = pc_update | (branch & zero).
  - imm_src is decoded from op: lw/I-type 00, sw 01, beq 10, jal 11, R-type 00, anything else 00.
- alu_op, internal:
  - 00 selects add.
  - 01 selects sub.
  - 10 decodes funct3/funct7b5 as follows: 000 gives add, or sub when op[5]&funct7b5. 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101 srl.
- alu_control codes: add 000, sub 001, and 010, or 011, xor 100, slt 101, sll 110, srl 111.
- States, with their actions (unlisted outputs are 0):
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_update=mem_ready. Stay in FETCH while !mem_ready, else go to DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). Next state by op: lw/sw go to MEMADR; R-type to EXECUTER; I-type to EXECUTEI; beq to BEQ; jal to JAL; any other op to ILLEGAL.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Hold until mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_retire=1. Go to FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1, asserted for every wait cycle. Hold until mem_ready. In the mem_ready cycle, instr_retire=1, then go to FETCH.
  - EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
  - EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_retire=1. Go to FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_retire=1. Go to FETCH.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB.
  - ILLEGAL: all enables 0, illegal_instr=1. The only exit is reset.
- Latency with mem_ready held at 1:
  - lw 5 cycles.
  - sw, R-type, I-type, jal 4 cycles.
  - beq 3 cycles.
  - Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Boundaries:
  - mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
  - Reset asserted mid-instruction abandons it; no further writes occur.
  - No state transition skips FETCH between instructions.
  - Unused state codes decode to ILLEGAL.

Decomposition:
- riscv_ctrl_pkg holds:
  - the state encodings,
  - opcode constants (LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111),
  - the alu_op and alu_control codes,
  - the mux-select codes.
- One sub-module, alu_decoder: combinational mapping of alu_op, funct3, funct7b5 and op[5] to alu_control. It is instantiated once.

Test Plan:
- Reset then op=R-type add (funct3=000, funct7b5=0), mem_ready=1 → states FETCH, DECODE, EXECUTER, ALUWB. alu_control=000 in EXECUTER; reg_write=1 and instr_retire=1 only in cycle 4.
- lw with mem_ready low for 2 cycles in MEMREAD → 7 cycles total; reg_write pulses once with result_src=01; mem_write never asserted.
- sw with mem_ready=0 for 1 cycle in MEMWRITE → mem_write=1 for 2 consecutive cycles; imm_src=01; instr_retire in the second of them.
- beq with zero=1, then beq with zero=0 → pc_write=1 in BEQ only for the first; each instruction takes 3 cycles.
- jal → pc_write=1 in JAL; reg_write=1 in ALUWB with result_src=00; imm_src=11.
- op=1111111 → DECODE goes to ILLEGAL and illegal_instr stays 1 for 20 cycles with no enables. Pulsing rst_n low mid-ILLEGAL returns the FSM to FETCH and clears the flag.
